// File: rtl/mips_writeback_stage.sv
// MIPS writeback stage: W pipeline register, load extraction, result mux,
// HI/LO registers and retired-instruction counter.
module mips_writeback_stage #(
    parameter int W        = 32,
    parameter int RA       = 5,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stallW,
    input  logic          flushW,
    input  logic          validM,
    input  logic          RegWriteM,
    input  logic          linkM,
    input  logic [2:0]    ResultSrcM,
    input  logic [2:0]    LoadTypeM,
    input  logic [RA-1:0] WriteRegM,
    input  logic [W-1:0]  ALUOutM,
    input  logic [W-1:0]  ReadDataM,
    input  logic [W-1:0]  PCPlus8M,
    input  logic [1:0]    HiLoWriteM,
    input  logic [2*W-1:0] HiLoDataM,
    output logic          RegWriteW,
    output logic [RA-1:0] WriteRegW,
    output logic [W-1:0]  ResultW,
    output logic [W-1:0]  HiW,
    output logic [W-1:0]  LoW,
    output logic [31:0]   retiredW
);

    typedef struct packed {
        logic          valid;
        logic          regWrite;
        logic          link;
        logic [2:0]    resultSrc;
        logic [2:0]    loadType;
        logic [RA-1:0] writeReg;
        logic [W-1:0]  aluOut;
        logic [W-1:0]  readData;
        logic [W-1:0]  pcPlus8;
    } stage_t;

    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [2:0] SRC_ALU = 3'd0;
    localparam logic [2:0] SRC_MEM = 3'd1;
    localparam logic [2:0] SRC_PC8 = 3'd2;
    localparam logic [2:0] SRC_HI  = 3'd3;
    localparam logic [2:0] SRC_LO  = 3'd4;

    stage_t      s;
    logic [W-1:0] hiQ;
    logic [W-1:0] loQ;
    logic [31:0]  retiredQ;

    logic         advance;
    assign advance = !flushW && !stallW;

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else if (flushW) begin
            s.valid <= 1'b0;
        end else if (!stallW) begin
            s.valid     <= validM;
            s.regWrite  <= RegWriteM;
            s.link      <= linkM;
            s.resultSrc <= ResultSrcM;
            s.loadType  <= LoadTypeM;
            s.writeReg  <= WriteRegM;
            s.aluOut    <= ALUOutM;
            s.readData  <= ReadDataM;
            s.pcPlus8   <= PCPlus8M;
        end
    end

    // HI/LO are written as the producer enters W so the next instruction sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiQ <= '0;
            loQ <= '0;
        end else if (advance && validM) begin
            if (HiLoWriteM[1]) hiQ <= HiLoDataM[2*W-1:W];
            if (HiLoWriteM[0]) loQ <= HiLoDataM[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retiredQ <= '0;
        end else if (s.valid && !stallW) begin
            retiredQ <= retiredQ + 32'd1;
        end
    end

    logic [31:0]  word;
    logic [1:0]   off;
    logic [7:0]   byteLane;
    logic [15:0]  halfLane;
    logic [W-1:0] loadData;

    assign word     = s.readData[31:0];
    assign off      = s.aluOut[1:0];
    assign byteLane = word[8*off +: 8];
    assign halfLane = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        loadData = W'(signed'(word));
        unique case (s.loadType)
            LD_LH:   loadData = W'(signed'(halfLane));
            LD_LHU:  loadData = W'(halfLane);
            LD_LB:   loadData = W'(signed'(byteLane));
            LD_LBU:  loadData = W'(byteLane);
            default: loadData = W'(signed'(word));
        endcase
    end

    always_comb begin
        ResultW = '0;
        unique case (s.resultSrc)
            SRC_ALU: ResultW = s.aluOut;
            SRC_MEM: ResultW = loadData;
            SRC_PC8: ResultW = s.pcPlus8;
            SRC_HI:  ResultW = hiQ;
            SRC_LO:  ResultW = loQ;
            default: ResultW = '0;
        endcase
    end

    assign WriteRegW = s.link ? RA'(LINK_REG) : s.writeReg;
    assign RegWriteW = s.valid && s.regWrite && (WriteRegW != '0);
    assign HiW       = hiQ;
    assign LoW       = loQ;
    assign retiredW  = retiredQ;

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Directed bench for mips_writeback_stage (W=32).
module tb_mips_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, stallW, flushW, validM, RegWriteM, linkM;
    logic [2:0]  ResultSrcM, LoadTypeM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM, ReadDataM, PCPlus8M;
    logic [1:0]  HiLoWriteM;
    logic [63:0] HiLoDataM;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW, HiW, LoW, retiredW;

    int checks = 0;
    int errors = 0;
    logic        expValid = 1'b0;
    logic [31:0] expRet   = 32'd0;

    mips_writeback_stage dut (
        .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
        .validM(validM), .RegWriteM(RegWriteM), .linkM(linkM),
        .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .PCPlus8M(PCPlus8M), .HiLoWriteM(HiLoWriteM), .HiLoDataM(HiLoDataM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .HiW(HiW), .LoW(LoW), .retiredW(retiredW)
    );

    always #5 clk = ~clk;

    // Tracks W validity and the expected retire count, then clocks once.
    task automatic step();
        if (rst) begin
            expRet = 0;
            expValid = 0;
        end else begin
            if (expValid && !stallW) expRet = expRet + 32'd1;
            if (flushW) expValid = 0;
            else if (!stallW) expValid = validM;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stallW = 0; flushW = 0; validM = 0;
        RegWriteM = 0; linkM = 0; ResultSrcM = 0; LoadTypeM = 0;
        WriteRegM = 0; ALUOutM = 0; ReadDataM = 0; PCPlus8M = 0;
        HiLoWriteM = 0; HiLoDataM = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if ({RegWriteW, WriteRegW, ResultW} !== 38'd0) begin
            errors++;
            $display("FAIL reset_w got %b %h %h exp 0", RegWriteW, WriteRegW, ResultW);
        end
        checks++;
        if ({HiW, LoW, retiredW} !== 96'd0) begin
            errors++;
            $display("FAIL reset_hilo got %h %h %h exp 0", HiW, LoW, retiredW);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [8] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd6, 3'd2};
        logic [1:0]  of  [8] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [31:0] exp [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8070,
                                 32'h0000_6050, 32'h8070_6050, 32'h0000_0050,
                                 32'h8070_6050, 32'h0000_8070};
        for (int i = 0; i < 8; i++) begin
            idle();
            validM = 1; RegWriteM = 1; WriteRegM = 5; ResultSrcM = 1;
            ReadDataM = 32'h8070_6050; LoadTypeM = lt[i];
            ALUOutM = {30'h1000, of[i]};
            step();
            checks++;
            if (ResultW !== exp[i]) begin
                errors++;
                $display("FAIL load%0d ResultW got %h exp %h", i, ResultW, exp[i]);
            end
            checks++;
            if (RegWriteW !== 1'b1 || WriteRegW !== 5'd5) begin
                errors++;
                $display("FAIL load%0d wr got %b %0d exp 1 5", i, RegWriteW, WriteRegW);
            end
        end
    endtask

    task automatic test_link();
        idle();
        validM = 1; RegWriteM = 1; linkM = 1; WriteRegM = 4;
        PCPlus8M = 32'h0040_0010; ResultSrcM = 2; ALUOutM = 32'h55;
        step();
        checks++;
        if (WriteRegW !== 5'd31 || ResultW !== 32'h0040_0010 || RegWriteW !== 1'b1) begin
            errors++;
            $display("FAIL link got %0d %h %b exp 31 00400010 1", WriteRegW, ResultW, RegWriteW);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        validM = 1; RegWriteM = 1; WriteRegM = 0; ALUOutM = 32'hDEAD_BEEF;
        step();
        checks++;
        if (RegWriteW !== 1'b0 || ResultW !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL zero_reg got %b %h exp 0 deadbeef", RegWriteW, ResultW);
        end
        idle();
        validM = 0; RegWriteM = 1; WriteRegM = 9;
        step();
        checks++;
        if (RegWriteW !== 1'b0) begin
            errors++;
            $display("FAIL invalid_wr got %b exp 0", RegWriteW);
        end
    endtask

    task automatic test_hilo();
        idle();
        validM = 1; HiLoWriteM = 3; HiLoDataM = {32'h1, 32'h2};
        step();
        idle();
        validM = 1; RegWriteM = 1; WriteRegM = 8; ResultSrcM = 3;
        step();
        checks++;
        if (ResultW !== 32'h1 || RegWriteW !== 1'b1) begin
            errors++;
            $display("FAIL mfhi got %h %b exp 1 1", ResultW, RegWriteW);
        end
        idle();
        validM = 1; RegWriteM = 1; WriteRegM = 8; ResultSrcM = 4;
        HiLoWriteM = 1; HiLoDataM = {32'hAAAA, 32'h5};
        step();
        checks++;
        if (ResultW !== 32'h5 || HiW !== 32'h1 || LoW !== 32'h5) begin
            errors++;
            $display("FAIL lo_only got %h %h %h exp 5 1 5", ResultW, HiW, LoW);
        end
        idle();
        validM = 1; HiLoWriteM = 2; HiLoDataM = {32'h77, 32'h99};
        step();
        checks++;
        if (HiW !== 32'h77 || LoW !== 32'h5) begin
            errors++;
            $display("FAIL hi_only got %h %h exp 77 5", HiW, LoW);
        end
        idle();
        validM = 0; HiLoWriteM = 3; HiLoDataM = {32'h33, 32'h44};
        step();
        checks++;
        if (HiW !== 32'h77 || LoW !== 32'h5) begin
            errors++;
            $display("FAIL hilo_invalid got %h %h exp 77 5", HiW, LoW);
        end
        idle();
        validM = 1; ResultSrcM = 6; ALUOutM = 32'h1234;
        step();
        checks++;
        if (ResultW !== 32'h0) begin
            errors++;
            $display("FAIL src6 got %h exp 0", ResultW);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        validM = 1; RegWriteM = 1; WriteRegM = 7; ALUOutM = 32'h1234;
        step();
        for (int i = 0; i < 3; i++) begin
            idle();
            stallW = 1; validM = 1; RegWriteM = 1; WriteRegM = 12;
            ALUOutM = 32'h9999; HiLoWriteM = 3; HiLoDataM = {32'hEE, 32'hFF};
            step();
            checks++;
            if (ResultW !== 32'h1234 || WriteRegW !== 5'd7 || RegWriteW !== 1'b1) begin
                errors++;
                $display("FAIL stall%0d got %h %0d %b exp 1234 7 1", i, ResultW, WriteRegW, RegWriteW);
            end
            checks++;
            if (retiredW !== expRet || HiW !== 32'h77 || LoW !== 32'h5) begin
                errors++;
                $display("FAIL stall%0d ret/hilo got %h %h %h exp %h 77 5", i, retiredW, HiW, LoW, expRet);
            end
        end
        idle();
        flushW = 1; validM = 1; RegWriteM = 1; WriteRegM = 12;
        step();
        checks++;
        if (RegWriteW !== 1'b0 || retiredW !== expRet) begin
            errors++;
            $display("FAIL flush got %b %h exp 0 %h", RegWriteW, retiredW, expRet);
        end
    endtask

    task automatic test_flush_stall();
        idle();
        validM = 1; RegWriteM = 1; WriteRegM = 3; ALUOutM = 32'hABCD;
        step();
        idle();
        flushW = 1; stallW = 1; validM = 1; RegWriteM = 1; WriteRegM = 3;
        HiLoWriteM = 3; HiLoDataM = {32'h1, 32'h1};
        step();
        checks++;
        if (RegWriteW !== 1'b0 || retiredW !== expRet || HiW !== 32'h77) begin
            errors++;
            $display("FAIL flush_stall got %b %h %h exp 0 %h 77", RegWriteW, retiredW, HiW, expRet);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rg [4] = '{5'd1, 5'd2, 5'd0, 5'd30};
        logic [31:0] av [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic        ew [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            idle();
            validM = 1; RegWriteM = 1; WriteRegM = rg[i]; ALUOutM = av[i];
            step();
            checks++;
            if (ResultW !== av[i] || RegWriteW !== ew[i] || retiredW !== expRet) begin
                errors++;
                $display("FAIL b2b%0d got %h %b %h exp %h %b %h", i, ResultW, RegWriteW, retiredW, av[i], ew[i], expRet);
            end
        end
    endtask

    task automatic test_wrap();
        idle();
        step();
        step();
        force dut.retiredQ = 32'hFFFF_FFFF;
        #1;
        release dut.retiredQ;
        expRet = 32'hFFFF_FFFF;
        checks++;
        if (retiredW !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL preload got %h exp ffffffff", retiredW);
        end
        validM = 1;
        step();
        idle();
        step();
        checks++;
        if (retiredW !== 32'h0 || expRet !== retiredW) begin
            errors++;
            $display("FAIL wrap got %h exp 0", retiredW);
        end
    endtask

    task automatic test_rst_mid();
        idle();
        validM = 1; RegWriteM = 1; WriteRegM = 6; ALUOutM = 32'h42;
        HiLoWriteM = 3; HiLoDataM = {32'h8, 32'h9};
        step();
        idle();
        validM = 1; RegWriteM = 1; WriteRegM = 6; ALUOutM = 32'h43;
        step();
        rst = 1; stallW = 1; flushW = 1;
        step();
        checks++;
        if ({RegWriteW, WriteRegW, ResultW, HiW, LoW, retiredW} !== 134'd0) begin
            errors++;
            $display("FAIL rst_mid got %b %0d %h %h %h %h exp 0", RegWriteW, WriteRegW, ResultW, HiW, LoW, retiredW);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_loads();
        test_link();
        test_zero_reg();
        test_hilo();
        test_stall_flush();
        test_flush_stall();
        test_back_to_back();
        test_wrap();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_writeback_stage.md
MIPS_WRITEBACK_STAGE -- requirements
Module: mips_writeback_stage

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- W, 32, datapath width; W SHALL be 32 or 64.
- RA, 5, register-address width.
- LINK_REG, 31, destination register for link writes.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk, in, 1, the single clock; all state updates on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- stallW, in, 1, hold the stage register.
- flushW, in, 1, load a bubble.
- validM, in, 1, M-stage instruction is valid.
- RegWriteM, in, 1, instruction writes the register file.
- linkM, in, 1, destination is forced to LINK_REG.
- ResultSrcM, in, 3, 0=ALU, 1=MEM, 2=PC+8, 3=HI, 4=LO.
- LoadTypeM, in, 3, 0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU.
- WriteRegM, in, RA, destination register.
- ALUOutM, in, W, ALU result; bits [1:0] are the load byte offset.
- ReadDataM, in, W, raw memory word.
- PCPlus8M, in, W, link value.
- HiLoWriteM, in, 2, bit [1] writes HI, bit [0] writes LO.
- HiLoDataM, in, 2W, {hi, lo} from the multiply/divide unit.
- RegWriteW, out, 1, register-file write enable.
- WriteRegW, out, RA, register-file write address.
- ResultW, out, W, register-file write data.
- HiW, out, W, HI register.
- LoW, out, W, LO register.
- retiredW, out, 32, retired-instruction count.

Function
REQ-003 The stage register SHALL hold valid, RegWrite, link, ResultSrc, LoadType, WriteReg, ALUOut, ReadData and PCPlus8.
REQ-004 Per clock edge, with priority in this order:
- rst: all state cleared.
- flushW: valid cleared, other stage fields don't-care.
- stallW: stage register holds.
- otherwise: stage register captures the M-stage inputs.
REQ-005 Latency SHALL be 1 cycle from M inputs to W outputs; ResultW, WriteRegW and RegWriteW SHALL be combinational from the stage register and HI/LO.
REQ-006 RegWriteW SHALL = valid & RegWrite & (WriteRegW != 0).
REQ-007 WriteRegW SHALL = LINK_REG when link, else the captured WriteReg.
REQ-008 Load extraction, little-endian:
- Byte lane = offset[1:0]; halfword lane = offset[1]; offset[0] is ignored for LH/LHU, and offset[1:0] is ignored for LW.
- LB and LH SHALL sign-extend to W; LBU and LHU SHALL zero-extend.
- LoadType 5-7 SHALL behave as LW.
- With W=64, LW SHALL sign-extend bits [31:0].
REQ-009 ResultW by ResultSrc:
- 0: ALUOut.
- 1: extracted load data.
- 2: PCPlus8.
- 3: HiW.
- 4: LoW.
- 5-7: 0.
REQ-010 HI/LO SHALL update at an edge only when rst=0, flushW=0, stallW=0 and validM=1:
- HI <= HiLoDataM[2W-1:W] if HiLoWriteM[1].
- LO <= HiLoDataM[W-1:0] if HiLoWriteM[0].
- Each half SHALL be written independently.
REQ-011 An instruction reading HI/LO in W SHALL see a write made by the instruction that entered W one cycle earlier, with no extra bubble.
REQ-012 retiredW SHALL increment by 1 at each edge where rst=0, valid=1 and stallW=0.
- An edge where flushW=1 and stallW=0 SHALL still count a valid instruction leaving W.
- The count SHALL wrap from 0xFFFFFFFF to 0.
REQ-013 Simultaneous flushW and stallW SHALL flush.

Reset
REQ-014 On rst at a clock edge, all of the following SHALL be 0 in the next cycle:
- valid and every stage-register field.
- HiW, LoW and retiredW.
- Therefore RegWriteW=0, WriteRegW=0, ResultW=0.
REQ-015 rst asserted mid-stall or mid-flush SHALL override both.
REQ-016 No output SHALL be X after the first reset edge.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- LB, ReadDataM=0x8070_6050, ALUOutM[1:0]=3 -> ResultW=0xFFFF_FF80; LBU -> 0x0000_0080.
- LH at offset 2 (same data) -> 0xFFFF_8070; LHU at offset 1 -> 0x0000_6050.
- linkM=1, WriteRegM=4, PCPlus8M=0x0040_0010, ResultSrc=2 -> WriteRegW=31, ResultW=0x0040_0010, RegWriteW=1.
- RegWriteM=1, WriteRegM=0 -> RegWriteW=0.
- mult writes {0x1,0x2} (HiLoWrite=3), next instruction mfhi -> ResultW=1.
- Repeat with HiLoWrite=1 -> HiW unchanged, LoW=2.
- Stall 3 cycles -> outputs frozen and retiredW unchanged; flush -> RegWriteW=0 next cycle.
- flush+stall together -> bubble.
- Preload retiredW=0xFFFF_FFFF via 2^32-1 retirements or force -> wraps to 0.
- rst mid-stream -> all outputs 0 next cycle.
